mem_swap_seq: RTL
=================

# mem_swap_seq

Parametrised memory swap sequencer: owns a DEPTH x WIDTH register-array memory, a temporary register and a control FSM that exchanges two words or reverses an address range in place. It is the next-generation swapper used by the memory-swapper subsystem. It adds host write/read access, a start/ready/done handshake, range checking and a multi-pair reverse mode to the fixed single-swap sequencer.

## Interface
Parameters:
- WIDTH, 8, data word width (>= 1)
- DEPTH, 16, number of words (>= 2, need not be a power of two); AW = $clog2(DEPTH) is derived and not overridable

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- wr_en  in  1  host write strobe; honoured only while ready=1
- wr_addr  in  AW  host write address
- wr_data  in  WIDTH  host write data
- rd_addr  in  AW  host read address, sampled every cycle
- rd_data  out  WIDTH  registered read data (mem[rd_addr] from previous edge)
- start  in  1  operation request; sampled only while ready=1
- mode  in  1  0 = swap addr_a/addr_b, 1 = reverse range [addr_a..addr_b]
- addr_a  in  AW  first address / range low
- addr_b  in  AW  second address / range high
- ready  out  1  FSM in IDLE, host access and start accepted
- busy  out  1  operation in progress (= ~ready)
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse, coincident with done, on out-of-range address
- swap_cnt  out  16  count of completed word-pair exchanges, wraps at 2^16

## Operation
- States: IDLE, LOAD, MOVE, STORE, DONE. Registers lo, hi (AW+1 bits), tmp (WIDTH), op_mode, err_q.
- IDLE: ready=1. On start: latch mode, lo=addr_a, hi=addr_b.
  - If addr_a >= DEPTH or addr_b >= DEPTH: err_q=1, go to DONE; memory untouched.
  - Else if mode=1 and addr_a >= addr_b: go to DONE; no exchanges.
  - Else go to LOAD.
- LOAD: tmp <= mem[lo].
- MOVE: mem[lo] <= mem[hi].
- STORE: mem[hi] <= tmp; swap_cnt++.
  - If op_mode=1 and lo+2 < hi (AW+1-bit compare): lo++, hi--, go to LOAD.
  - Else go to DONE.
- DONE: done=1, err=err_q; clear err_q; go to IDLE.
- Swap mode with addr_a == addr_b runs the full sequence. Contents are unchanged and swap_cnt increments.
- Host write: mem[wr_addr] <= wr_data on the edge where wr_en=1 and ready=1. wr_addr >= DEPTH is ignored. wr_en while busy is dropped.
- rd_data updates every cycle regardless of state. rd_addr >= DEPTH returns 0.
- start while busy is ignored and not queued.
- Memory contents are not reset.

## Timing
- Reset values: state IDLE, ready=1, busy=0, done=0, err=0, swap_cnt=0, rd_data=0, tmp=0.
- Start sampled at edge E0. For P exchanges (P=1 for swap, P=floor((b-a+1)/2) for reverse):
  - LOAD/MOVE/STORE occupy 3P cycles.
  - done=1 in the cycle after edge E(3P).
  - ready=1 again after E(3P+1).
- Swap latency: done in cycle 4 after start, ready in cycle 5.
- Error or empty reverse: done (and err) in the cycle after E0; ready after E1.
- Simultaneous wr_en and start in IDLE: the write commits at E0, and LOAD (cycle after E0) sees the new value.
- Reset asserted mid-operation: FSM to IDLE immediately, outputs to reset values, done not pulsed. Memory retains partially swapped contents.
- swap_cnt wraps from 0xFFFF to 0x0000 without flag.

## Test plan
- Default params. Write mem[3]=0xA5, mem[9]=0x3C. Swap a=3, b=9 -> done in cycle 4; mem[3]=0x3C, mem[9]=0xA5; swap_cnt=1; err=0.
- Write mem[i]=i for 0..15. Reverse a=2, b=7 -> 3 exchanges, done after edge 9 plus one cycle; mem[2..7]=7,6,5,4,3,2; swap_cnt=3.
- DEPTH=12. Swap a=5, b=13 -> err=1 and done=1 in the cycle after start; memory unchanged; swap_cnt unchanged.
- Reverse a=6, b=6, then a=8, b=4 -> each gives done one cycle after start, no memory change, swap_cnt unchanged.
- Start swap 1<->2. Pulse wr_en to addr 1 and a second start while busy -> both ignored; result is a pure swap of the original values.
- Start reverse 0..15. Assert reset after 5 cycles -> ready=1, done=0, swap_cnt=0. Pair (0,15) swapped; pair (1,14) has mem[1] overwritten with mem[14].

Source files
------------

// File: rtl/mem_swap_seq_if.sv
// Bundles the host access port and the operation handshake of mem_swap_seq.
// Ports: wr_* host write, rd_* registered host read, start/mode/addr_a/addr_b
// request, ready/busy/done/err status, swap_cnt exchange counter.
interface mem_swap_seq_if #(
   parameter int WIDTH = 8,
   parameter int AW    = 4
);
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [WIDTH-1:0] wr_data;
   logic [AW-1:0]    rd_addr;
   logic [WIDTH-1:0] rd_data;
   logic             start;
   logic             mode;
   logic [AW-1:0]    addr_a;
   logic [AW-1:0]    addr_b;
   logic             ready;
   logic             busy;
   logic             done;
   logic             err;
   logic [15:0]      swap_cnt;

   // Host side: drives requests, observes status.
   modport master (
      output wr_en, wr_addr, wr_data, rd_addr, start, mode, addr_a, addr_b,
      input  rd_data, ready, busy, done, err, swap_cnt
   );

   // Sequencer side.
   modport slave (
      input  wr_en, wr_addr, wr_data, rd_addr, start, mode, addr_a, addr_b,
      output rd_data, ready, busy, done, err, swap_cnt
   );
endinterface

// File: rtl/mem_swap_seq.sv
// Memory swap sequencer: swaps two words or reverses a range in a DEPTH x WIDTH array.
// Latency: swap done 4 cycles after start, reverse 3P+1; error/empty done next cycle.
// Backpressure: start and host writes accepted only while ready; otherwise dropped.
// Ports: clk, reset (async, active-high), bus (mem_swap_seq_if.slave).
module mem_swap_seq #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input logic          clk,
   input logic          reset,
   mem_swap_seq_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE_W   = (AW+1)'(1);
   localparam logic [AW:0] TWO_W   = (AW+1)'(2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_MOVE,
      S_STORE,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [AW:0]      lo_q, lo_d;
   logic [AW:0]      hi_q, hi_d;
   logic [WIDTH-1:0] tmp_q, tmp_d;
   logic             op_mode_q, op_mode_d;
   logic             err_q, err_d;
   logic             ready_q, ready_d;
   logic             done_q, done_d;
   logic             err_pls_q, err_pls_d;
   logic [15:0]      swap_cnt_q, swap_cnt_d;
   logic [WIDTH-1:0] rd_data_q, rd_data_d;

   logic [WIDTH-1:0] mem [DEPTH];
   logic             mem_we;
   logic [AW-1:0]    mem_waddr;
   logic [WIDTH-1:0] mem_wdata;

   logic a_ok, b_ok, wr_ok, rd_ok;

   assign a_ok  = {1'b0, bus.addr_a}  < DEPTH_W;
   assign b_ok  = {1'b0, bus.addr_b}  < DEPTH_W;
   assign wr_ok = {1'b0, bus.wr_addr} < DEPTH_W;
   assign rd_ok = {1'b0, bus.rd_addr} < DEPTH_W;

   always_comb begin
      state_d    = state_q;
      lo_d       = lo_q;
      hi_d       = hi_q;
      tmp_d      = tmp_q;
      op_mode_d  = op_mode_q;
      err_d      = err_q;
      swap_cnt_d = swap_cnt_q;
      mem_we     = 1'b0;
      mem_waddr  = '0;
      mem_wdata  = '0;
      rd_data_d  = rd_ok ? mem[bus.rd_addr] : '0;

      case (state_q)
         S_IDLE: begin
            if (bus.wr_en && wr_ok) begin
               mem_we    = 1'b1;
               mem_waddr = bus.wr_addr;
               mem_wdata = bus.wr_data;
            end
            if (bus.start) begin
               op_mode_d = bus.mode;
               lo_d      = {1'b0, bus.addr_a};
               hi_d      = {1'b0, bus.addr_b};
               if (!a_ok || !b_ok) begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end else if (bus.mode && (bus.addr_a >= bus.addr_b)) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_LOAD;
               end
            end
         end
         S_LOAD: begin
            tmp_d   = mem[lo_q[AW-1:0]];
            state_d = S_MOVE;
         end
         S_MOVE: begin
            mem_we    = 1'b1;
            mem_waddr = lo_q[AW-1:0];
            mem_wdata = mem[hi_q[AW-1:0]];
            state_d   = S_STORE;
         end
         S_STORE: begin
            mem_we     = 1'b1;
            mem_waddr  = hi_q[AW-1:0];
            mem_wdata  = tmp_q;
            swap_cnt_d = swap_cnt_q + 16'd1;
            // Another pair remains only if the pointers stay at least one apart
            // after stepping inward; the extra bit keeps lo+2 from wrapping.
            if (op_mode_q && ((lo_q + TWO_W) < hi_q)) begin
               lo_d    = lo_q + ONE_W;
               hi_d    = hi_q - ONE_W;
               state_d = S_LOAD;
            end else begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            err_d   = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Status outputs are registered from the next state so they line up
      // exactly with the state they describe.
      ready_d   = (state_d == S_IDLE);
      done_d    = (state_d == S_DONE);
      err_pls_d = (state_d == S_DONE) && err_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         lo_q       <= '0;
         hi_q       <= '0;
         tmp_q      <= '0;
         op_mode_q  <= 1'b0;
         err_q      <= 1'b0;
         ready_q    <= 1'b1;
         done_q     <= 1'b0;
         err_pls_q  <= 1'b0;
         swap_cnt_q <= '0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         lo_q       <= lo_d;
         hi_q       <= hi_d;
         tmp_q      <= tmp_d;
         op_mode_q  <= op_mode_d;
         err_q      <= err_d;
         ready_q    <= ready_d;
         done_q     <= done_d;
         err_pls_q  <= err_pls_d;
         swap_cnt_q <= swap_cnt_d;
         rd_data_q  <= rd_data_d;
      end
   end

   // Storage is deliberately not reset: an interrupted operation leaves its
   // partial result in place.
   always_ff @(posedge clk) begin
      if (mem_we && !reset) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   assign bus.rd_data  = rd_data_q;
   assign bus.ready    = ready_q;
   assign bus.busy     = ~ready_q;
   assign bus.done     = done_q;
   assign bus.err      = err_pls_q;
   assign bus.swap_cnt = swap_cnt_q;
endmodule
